// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM-side word/read-data handshake of the SPI slave front end.
interface spi_slave_if_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (output SS_n, MOSI, tx_data, tx_valid,
                    input  MISO, rx_data, rx_valid);
    modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                    output MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave: deserialises 10-bit command words for a RAM and serialises read data back on MISO.
module spi_slave_if (
    input  logic          clk,
    input  logic          rst,
    spi_slave_if_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t     state_q, state_d;
    logic [9:0] rx_shift;
    logic [3:0] bit_cnt;
    logic       word_done;
    logic       rd_addr_flag;
    logic       need_high;
    logic       tx_arm;
    logic [7:0] tx_shift;
    logic [3:0] tx_cnt;
    logic       data_state;
    logic       capture;

    assign data_state = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    assign capture    = data_state && (bit_cnt != 4'd9);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.SS_n && !need_high) state_d = CHK_CMD;
            CHK_CMD: begin
                if (bus.SS_n)          state_d = IDLE;
                else if (!bus.MOSI)    state_d = WRITE;
                else if (rd_addr_flag) state_d = READ_DATA;
                else                   state_d = READ_ADD;
            end
            default: if (bus.SS_n) state_d = IDLE;
        endcase
    end

    // need_high keeps a frame that was live across reset from being picked up mid-stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift     <= '0;
            bit_cnt      <= '0;
            word_done    <= 1'b0;
            rd_addr_flag <= 1'b0;
            need_high    <= 1'b1;
            tx_arm       <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.MISO     <= 1'b0;
        end else begin
            word_done    <= 1'b0;
            bus.rx_valid <= word_done;
            if (bus.SS_n) begin
                need_high <= 1'b0;
                bit_cnt   <= '0;
                tx_arm    <= 1'b0;
                tx_shift  <= '0;
                tx_cnt    <= '0;
                bus.MISO  <= 1'b0;
            end else begin
                if (state_q == CHK_CMD) begin
                    rx_shift <= {9'd0, bus.MOSI};
                    bit_cnt  <= '0;
                end
                if (capture) begin
                    rx_shift <= {rx_shift[8:0], bus.MOSI};
                    bit_cnt  <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        bus.rx_data <= {rx_shift[8:0], bus.MOSI};
                        word_done   <= 1'b1;
                        if (state_q == READ_ADD)  rd_addr_flag <= 1'b1;
                        if (state_q == READ_DATA) rd_addr_flag <= 1'b0;
                    end
                end
                // Read data may only be taken once the rx_valid pulse is out.
                if (word_done && state_q == READ_DATA) tx_arm <= 1'b1;
                if (tx_cnt != 4'd0) begin
                    bus.MISO <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    tx_cnt   <= tx_cnt - 4'd1;
                end else begin
                    bus.MISO <= 1'b0;
                    if (tx_arm && bus.tx_valid) begin
                        tx_shift <= bus.tx_data;
                        tx_cnt   <= 4'd8;
                        tx_arm   <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: table of write/read frames plus abort, reset and MISO sequences.
module tb_spi_slave_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    spi_slave_if_if bus ();

    spi_slave_if dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dbl = 0;
    int miso_bad = 0;
    bit miso_chk = 1'b1;
    logic prev_rv = 1'b0;
    logic [9:0] q_rx[$];
    int q_cyc[$];

    typedef struct {
        logic [9:0] word;
        logic       flag;
    } vec_t;
    vec_t vecs[8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.rx_valid) begin
            q_rx.push_back(bus.rx_data);
            q_cyc.push_back(cyc);
        end
        if (bus.rx_valid && prev_rv) dbl++;
        prev_rv = bus.rx_valid;
        if (miso_chk && bus.MISO !== 1'b0) miso_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [9:0] w, input bit raise, output int ss_edge);
        @(negedge clk);
        bus.SS_n = 1'b0;
        ss_edge = cyc + 1;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            bus.MOSI = w[i];
        end
        if (raise) begin
            @(negedge clk);
            bus.SS_n = 1'b1;
            repeat (3) @(posedge clk);
            #2;
        end
    endtask

    task automatic check_word(input string name, input logic [9:0] exp, input int ss_edge);
        chk({name, "_pulses"}, q_rx.size(), 1);
        if (q_rx.size() > 0) begin
            chk({name, "_rx_data"}, {22'd0, q_rx[0]}, {22'd0, exp});
            chk({name, "_latency"}, q_cyc[0] - ss_edge, 11);
        end
        q_rx.delete();
        q_cyc.delete();
    endtask

    task automatic check_miso(input string name, input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk); #1;
            chk($sformatf("%s_bit%0d", name, i), {31'd0, bus.MISO}, {31'd0, d[i]});
        end
        @(posedge clk); #1;
        chk({name, "_after"}, {31'd0, bus.MISO}, 0);
    endtask

    initial begin
        int e, e2;
        vecs[0] = '{10'h0A5, 1'b0};
        vecs[1] = '{10'h13C, 1'b0};
        vecs[2] = '{10'h207, 1'b1};
        vecs[3] = '{10'h055, 1'b1};
        vecs[4] = '{10'h300, 1'b0};
        vecs[5] = '{10'h3FF, 1'b1};
        vecs[6] = '{10'h1FF, 1'b1};
        vecs[7] = '{10'h2AA, 1'b0};

        bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rx_data", {22'd0, bus.rx_data}, 0);
        chk("reset_rx_valid", {31'd0, bus.rx_valid}, 0);
        chk("reset_miso", {31'd0, bus.MISO}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].word, 1'b1, e);
            check_word($sformatf("vec%0d", v), vecs[v].word, e);
            chk($sformatf("vec%0d_flag", v), {31'd0, dut.rd_addr_flag}, {31'd0, vecs[v].flag});
        end

        // read address then read data, tx_valid arriving two cycles after rx_valid
        send_frame(10'h207, 1'b1, e);
        check_word("rdaddr", 10'h207, e);
        chk("rdaddr_flag", {31'd0, dut.rd_addr_flag}, 1);
        miso_chk = 1'b0;
        send_frame(10'h300, 1'b0, e);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hB6;
        @(posedge clk); #1;
        chk("rd_latch_miso", {31'd0, bus.MISO}, 0);
        bus.tx_data = 8'h00;
        check_miso("rd_b6", 8'hB6);
        @(negedge clk);
        bus.SS_n = 1'b1; bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk); #2;
        check_word("rddata", 10'h300, e);
        chk("rddata_flag", {31'd0, dut.rd_addr_flag}, 0);

        // tx_valid already high when the rx_valid pulse goes out
        miso_chk = 1'b1;
        send_frame(10'h207, 1'b1, e);
        check_word("rdaddr2", 10'h207, e);
        miso_chk = 1'b0;
        bus.tx_valid = 1'b1; bus.tx_data = 8'h5C;
        send_frame(10'h3C0, 1'b0, e);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        chk("pre_latch_miso", {31'd0, bus.MISO}, 0);
        check_miso("pre_5c", 8'h5C);
        @(negedge clk);
        bus.SS_n = 1'b1; bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk); #2;
        check_word("rddata2", 10'h3C0, e);
        miso_chk = 1'b1;

        // abort after 5 bits
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.MOSI = i[0];
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        repeat (15) @(posedge clk); #2;
        chk("abort_pulses", q_rx.size(), 0);
        chk("abort_flag", {31'd0, dut.rd_addr_flag}, 0);
        send_frame(10'h0F0, 1'b1, e);
        check_word("post_abort", 10'h0F0, e);

        // reset after 6 bits
        send_frame(10'h207, 1'b1, e);
        check_word("pre_rst", 10'h207, e);
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.MOSI = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_rx_data", {22'd0, bus.rx_data}, 0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 0);
        chk("rst_miso", {31'd0, bus.MISO}, 0);
        chk("rst_flag", {31'd0, dut.rd_addr_flag}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.MOSI = i[1];
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        repeat (3) @(posedge clk); #2;
        chk("rst_pulses", q_rx.size(), 0);
        send_frame(10'h12B, 1'b1, e);
        check_word("post_rst", 10'h12B, e);

        // back-to-back writes, one high cycle between them
        send_frame(10'h0C3, 1'b0, e);
        @(negedge clk);
        bus.SS_n = 1'b1;
        send_frame(10'h1E7, 1'b1, e2);
        chk("b2b_pulses", q_rx.size(), 2);
        if (q_rx.size() == 2) begin
            chk("b2b_first", {22'd0, q_rx[0]}, {22'd0, 10'h0C3});
            chk("b2b_first_lat", q_cyc[0] - e, 11);
            chk("b2b_second", {22'd0, q_rx[1]}, {22'd0, 10'h1E7});
            chk("b2b_second_lat", q_cyc[1] - e2, 11);
        end
        q_rx.delete();
        q_cyc.delete();

        chk("no_double_rx_valid", dbl, 0);
        chk("miso_quiet", miso_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
